// File: rtl/elevator_pkg.sv
// Shared state encoding and timing constants for the elevator scheduler.
// The SIM_* set shortens the tick so simulation finishes in a few thousand clocks.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam int N_FLOORS_DEF   = 8;
  localparam int FLOOR_W_DEF    = 3;
  localparam int TICK_DIV_DEF   = 33333333;
  localparam int MOVE_TICKS_DEF = 6;
  localparam int DOOR_TICKS_DEF = 9;

  localparam int SIM_TICK_DIV   = 4;
  localparam int SIM_MOVE_TICKS = 2;
  localparam int SIM_DOOR_TICKS = 3;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: tick is high for the one clock in which the count sits at TICK_DIV-1.
// Registered strobe; it is never stalled or cleared except by reset.
module tick_gen #(
  parameter int TICK_DIV = 33333333
) (
  input  logic clk100mhz,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);

  // The strobe is registered from the next count so it lines up with cnt == LAST.
  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/elevator_sched.sv
// Single-car SCAN scheduler: latches calls, picks direction, steps floors on tick-timed moves.
// All outputs registered; an IDLE call reaches moving/door_open two clocks after it is driven.
module elevator_sched
  import elevator_pkg::*;
#(
  parameter int N_FLOORS   = N_FLOORS_DEF,
  parameter int FLOOR_W    = FLOOR_W_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int MOVE_TICKS = MOVE_TICKS_DEF,
  parameter int DOOR_TICKS = DOOR_TICKS_DEF
) (
  input  logic                clk100mhz,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]  cur_floor,
  output logic                dir_up,
  output logic                moving,
  output logic                door_open,
  output logic [N_FLOORS-1:0] pending,
  output logic                arrive,
  output logic                tick
);

  localparam int TMAX = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [N_FLOORS-1:0] ONE = N_FLOORS'(1);

  function automatic logic any_above(input logic [N_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
    any_above = 1'b0;
    for (int i = 0; i < N_FLOORS; i++)
      if (i > int'(f)) any_above = any_above | v[i];
  endfunction

  function automatic logic any_below(input logic [N_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
    any_below = 1'b0;
    for (int i = 0; i < N_FLOORS; i++)
      if (i < int'(f)) any_below = any_below | v[i];
  endfunction

  state_t              state;
  logic [TW-1:0]       ticks_in_state;
  logic [N_FLOORS-1:0] req_in, pend_now, clr_mask;
  logic [FLOOR_W-1:0]  step_floor;
  logic                above, below, door_hold, step_done, arr_door, arr_ahead;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk100mhz(clk100mhz),
    .rst_n    (rst_n),
    .tick     (tick)
  );

  // A call for the open-door floor is swallowed and only holds the door.
  assign door_hold  = (state == DOOR) && call_req[cur_floor];
  assign req_in     = call_req & ~(door_hold ? (ONE << cur_floor) : '0);
  assign pend_now   = pending | req_in;
  assign above      = any_above(pending, cur_floor);
  assign below      = any_below(pending, cur_floor);
  assign step_floor = dir_up ? cur_floor + FLOOR_W'(1) : cur_floor - FLOOR_W'(1);
  assign step_done  = (state == MOVE) && tick && (ticks_in_state == TW'(MOVE_TICKS - 1));
  assign arr_door   = pend_now[step_floor];
  assign arr_ahead  = dir_up ? any_above(pend_now, step_floor) : any_below(pend_now, step_floor);

  always_comb begin
    clr_mask = '0;
    if (state == IDLE && pending[cur_floor])
      clr_mask = ONE << cur_floor;
    else if (step_done && arr_door)
      clr_mask = ONE << step_floor;
  end

  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ticks_in_state <= '0;
      cur_floor      <= '0;
      dir_up         <= 1'b1;
      moving         <= 1'b0;
      door_open      <= 1'b0;
      pending        <= '0;
      arrive         <= 1'b0;
    end else begin
      arrive  <= 1'b0;
      pending <= pend_now & ~clr_mask;
      case (state)
        IDLE: begin
          if (pending[cur_floor]) begin
            state          <= DOOR;
            door_open      <= 1'b1;
            ticks_in_state <= '0;
          end else if (above && (dir_up || !below)) begin
            dir_up         <= 1'b1;
            state          <= MOVE;
            moving         <= 1'b1;
            ticks_in_state <= '0;
          end else if (below) begin
            dir_up         <= 1'b0;
            state          <= MOVE;
            moving         <= 1'b1;
            ticks_in_state <= '0;
          end
        end
        MOVE: begin
          if (step_done) begin
            cur_floor      <= step_floor;
            arrive         <= 1'b1;
            ticks_in_state <= '0;
            if (arr_door) begin
              state     <= DOOR;
              moving    <= 1'b0;
              door_open <= 1'b1;
            end else if (!arr_ahead) begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end else if (tick) begin
            ticks_in_state <= ticks_in_state + TW'(1);
          end
        end
        DOOR: begin
          if (door_hold) begin
            ticks_in_state <= '0;
          end else if (tick) begin
            if (ticks_in_state == TW'(DOOR_TICKS - 1)) begin
              state          <= IDLE;
              door_open      <= 1'b0;
              ticks_in_state <= '0;
            end else begin
              ticks_in_state <= ticks_in_state + TW'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          moving    <= 1'b0;
          door_open <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_sched.sv
// Directed bench for elevator_sched using the short simulation timing set.
module tb_elevator_sched;
  import elevator_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] call_req = '0;
  logic [2:0] cur_floor;
  logic       dir_up, moving, door_open, arrive, tick;
  logic [7:0] pending;

  int tests_run = 0;
  int tests_failed = 0;

  elevator_sched #(
    .N_FLOORS  (8),
    .FLOOR_W   (3),
    .TICK_DIV  (SIM_TICK_DIV),
    .MOVE_TICKS(SIM_MOVE_TICKS),
    .DOOR_TICKS(SIM_DOOR_TICKS)
  ) dut (
    .clk100mhz(clk),
    .rst_n    (rst_n),
    .call_req (call_req),
    .cur_floor(cur_floor),
    .dir_up   (dir_up),
    .moving   (moving),
    .door_open(door_open),
    .pending  (pending),
    .arrive   (arrive),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic wait_door(input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (door_open === lvl) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic pulse_call(input logic [7:0] v);
    call_req = v;
    @(negedge clk);
    call_req = '0;
  endtask

  task automatic test_reset;
    int c1, c2, cyc;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (cur_floor !== 3'd0) begin tests_failed++; $display("FAIL reset_floor: got %0d exp 0", cur_floor); end
    tests_run++; if (dir_up !== 1'b1) begin tests_failed++; $display("FAIL reset_dir: got %b exp 1", dir_up); end
    tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("FAIL reset_pending: got %h exp 00", pending); end
    tests_run++; if ({moving, door_open, arrive, tick} !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags: got %b exp 0000", {moving, door_open, arrive, tick}); end
    rst_n = 1'b1;
    c1 = -1; c2 = -1; cyc = 0;
    for (int i = 0; i < 20 && c2 < 0; i++) begin
      @(negedge clk); cyc++;
      if (tick === 1'b1) begin if (c1 < 0) c1 = cyc; else c2 = cyc; end
    end
    tests_run++; if (c1 != 3) begin tests_failed++; $display("FAIL first_tick: got cycle %0d exp 3", c1); end
    tests_run++; if (c2 - c1 != 4) begin tests_failed++; $display("FAIL tick_period: got %0d exp 4", c2 - c1); end
  endtask

  task automatic test_single_up;
    logic [2:0] q[$];
    bit ok;
    int n;
    pulse_call(8'h08);
    tests_run++; if (pending !== 8'h08) begin tests_failed++; $display("FAIL up_latch: got %h exp 08", pending); end
    @(negedge clk);
    tests_run++; if ({moving, dir_up} !== 2'b11) begin tests_failed++; $display("FAIL up_start: got moving/dir %b exp 11", {moving, dir_up}); end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (arrive === 1'b1) q.push_back(cur_floor);
      if (door_open === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL up_door_timeout: got no door exp door at 3"); end
    tests_run++; if (q.size() != 3) begin tests_failed++; $display("FAIL up_arrive_count: got %0d exp 3", q.size()); end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (i >= q.size() || q[i] !== 3'(i + 1)) begin tests_failed++; $display("FAIL up_arrive_floor[%0d]: got %0d exp %0d", i, (i < q.size()) ? q[i] : 3'd7, i + 1); end
    end
    tests_run++; if ({cur_floor, pending} !== {3'd3, 8'h00}) begin tests_failed++; $display("FAIL up_door_state: got floor %0d pending %h exp 3 00", cur_floor, pending); end
    n = 0;
    while (door_open === 1'b1 && n < 50) begin n++; @(negedge clk); end
    tests_run++; if (n < 9 || n > 12) begin tests_failed++; $display("FAIL up_door_len: got %0d exp 9..12", n); end
    tests_run++; if ({moving, door_open} !== 2'b00) begin tests_failed++; $display("FAIL up_idle: got %b exp 00", {moving, door_open}); end
  endtask

  task automatic test_scan;
    logic [2:0] arr_q[$];
    logic [2:0] door_q[$];
    logic [2:0] exp_seq [7] = '{3'd3, 3'd4, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    int up_cnt, dn_cnt;
    bit ok, prev_door;
    pulse_call(8'h04);
    wait_door(1'b1, 200, ok);
    wait_door(1'b0, 60, ok);
    tests_run++; if (!ok || cur_floor !== 3'd2) begin tests_failed++; $display("FAIL scan_setup: got floor %0d exp 2", cur_floor); end
    pulse_call(8'h20);
    for (int i = 0; i < 5 && moving !== 1'b1; i++) @(negedge clk);
    pulse_call(8'h02);
    up_cnt = 0; dn_cnt = 0; prev_door = 1'b0; ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (arrive === 1'b1) begin arr_q.push_back(cur_floor); if (dir_up) up_cnt++; else dn_cnt++; end
      if (door_open === 1'b1 && !prev_door) door_q.push_back(cur_floor);
      if (door_open !== 1'b1 && prev_door && door_q.size() == 2) begin ok = 1'b1; break; end
      prev_door = (door_open === 1'b1);
      @(negedge clk);
    end
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL scan_timeout: got %0d doors exp 2", door_q.size()); end
    for (int i = 0; i < 7; i++) begin
      tests_run++;
      if (i >= arr_q.size() || arr_q[i] !== exp_seq[i]) begin tests_failed++; $display("FAIL scan_arrive[%0d]: got %0d exp %0d", i, (i < arr_q.size()) ? arr_q[i] : 3'd0, exp_seq[i]); end
    end
    tests_run++; if (up_cnt != 3 || dn_cnt != 4) begin tests_failed++; $display("FAIL scan_dir_counts: got up %0d down %0d exp 3 4", up_cnt, dn_cnt); end
    tests_run++; if (door_q.size() != 2 || door_q[0] !== 3'd5 || door_q[1] !== 3'd1) begin tests_failed++; $display("FAIL scan_doors: got %0d doors exp floors 5 then 1", door_q.size()); end
  endtask

  task automatic test_door_hold;
    int nt, nt2;
    bit ok;
    pulse_call(8'h10);
    wait_door(1'b1, 200, ok);
    tests_run++; if (!ok || cur_floor !== 3'd4) begin tests_failed++; $display("FAIL hold_setup: got floor %0d exp 4", cur_floor); end
    nt = 0;
    for (int i = 0; i < 30; i++) begin
      if (tick === 1'b1 && door_open === 1'b1) nt++;
      if (nt == 2) break;
      @(negedge clk);
    end
    pulse_call(8'h10);
    tests_run++; if (pending[4] !== 1'b0 || door_open !== 1'b1) begin tests_failed++; $display("FAIL hold_no_latch: got pending %h door %b exp bit4=0 door=1", pending, door_open); end
    nt2 = 0;
    for (int i = 0; i < 60 && door_open === 1'b1; i++) begin
      if (tick === 1'b1) nt2++;
      @(negedge clk);
    end
    tests_run++; if (nt2 != 3) begin tests_failed++; $display("FAIL hold_extra_ticks: got %0d exp 3", nt2); end
  endtask

  task automatic test_same_floor;
    bit ok;
    logic [2:0] fl [2] = '{3'd7, 3'd0};
    logic [7:0] req;
    for (int k = 0; k < 2; k++) begin
      req = 8'h01 << fl[k];
      pulse_call(req);
      wait_door(1'b1, 300, ok);
      wait_door(1'b0, 60, ok);
      tests_run++; if (!ok || cur_floor !== fl[k]) begin tests_failed++; $display("FAIL same_setup[%0d]: got floor %0d exp %0d", k, cur_floor, fl[k]); end
      pulse_call(req);
      @(negedge clk);
      tests_run++; if ({door_open, moving, pending} !== {1'b1, 1'b0, 8'h00}) begin tests_failed++; $display("FAIL same_door[%0d]: got door %b moving %b pending %h exp 1 0 00", k, door_open, moving, pending); end
      wait_door(1'b0, 60, ok);
    end
  endtask

  task automatic test_reset_mid_move;
    bit ok, bad;
    pulse_call(8'h80);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (arrive === 1'b1 && cur_floor === 3'd3) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    tests_run++; if (!ok || moving !== 1'b1 || cur_floor !== 3'd3) begin tests_failed++; $display("FAIL rst_setup: got floor %0d moving %b exp 3 1", cur_floor, moving); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if ({cur_floor, dir_up, moving, door_open, arrive, tick} !== {3'd0, 1'b1, 4'b0000}) begin tests_failed++; $display("FAIL rst_async: got floor %0d dir %b flags %b exp 0 1 0000", cur_floor, dir_up, {moving, door_open, arrive, tick}); end
    tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("FAIL rst_pending: got %h exp 00", pending); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (arrive !== 1'b0 || moving !== 1'b0 || door_open !== 1'b0 || cur_floor !== 3'd0) bad = 1'b1;
    end
    tests_run++; if (bad !== 1'b0) begin tests_failed++; $display("FAIL rst_after_release: got activity exp quiet at floor 0"); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_up();
    test_scan();
    test_door_hold();
    test_same_floor();
    test_reset_mid_move();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
